marquee_calc_ctrl: RTL

MARQUEE_CALC_CTRL -- requirements
Module: marquee_calc_ctrl

---
 rtl/marquee_calc_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/marquee_calc_ctrl.sv
// marquee_calc_ctrl
// Drives an N_DIGITS character display either as a scrolling marquee of
// msg or as a tiny single-digit calculator (A op B = result).
// Character codes: 0-9 digits, 26 '+', 27 '-', 28 '*', 29 '/', 30 'E', 31 blank.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous, active-high reset
//   tick       slow-rate enable pulse (marquee scroll / field increment)
//   step       debounced button pulse (calculator state advance)
//   mode       1 = marquee, 0 = calculator
//   direction  marquee scroll direction, 1 = forward, 0 = backward
//   msg        message, char k at [5k+4:5k]
//   digit_code registered display codes, position i at [5i+4:5i],
//              position N_DIGITS-1 is leftmost
//
// Build option: define MARQUEE_PAUSE_EN to let step toggle a marquee pause.
module marquee_calc_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int MSG_LEN  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    step,
    input  logic                    mode,
    input  logic                    direction,
    input  logic [5*MSG_LEN-1:0]    msg,
    output logic [5*N_DIGITS-1:0]   digit_code
);

    localparam int OFF_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MSG_LEN - 1);

    localparam logic [4:0] CH_PLUS  = 5'd26;
    localparam logic [4:0] CH_MINUS = 5'd27;
    localparam logic [4:0] CH_ERR   = 5'd30;
    localparam logic [4:0] CH_BLANK = 5'd31;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {ENTER_A, ENTER_OP, ENTER_B, SHOW} state_t;

    state_t                 state, state_n;
    logic [OFF_W-1:0]       offset, offset_n;
    logic [3:0]             a, a_n, b, b_n;
    logic [1:0]             op, op_n;
    logic                   mode_q;
    logic                   mode_chg;
    logic [5*N_DIGITS-1:0]  disp_n;
    logic signed [7:0]      res;
    logic [7:0]             mag;
`ifdef MARQUEE_PAUSE_EN
    logic                   pause, pause_n;
`endif

    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Message index shown at display position pos for a given scroll offset.
    function automatic int char_idx(input logic [OFF_W-1:0] off, input int pos);
        return (int'(off) + N_DIGITS - 1 - pos) % MSG_LEN;
    endfunction

    // Operands are 0..9, so the result spans -9..81; 8-bit signed holds it.
    function automatic logic signed [7:0] calc_result(input logic [3:0] x,
                                                      input logic [1:0] o,
                                                      input logic [3:0] y);
        logic signed [7:0] sx, sy;
        sx = signed'({4'b0000, x});
        sy = signed'({4'b0000, y});
        case (o)
            OP_ADD:  return sx + sy;
            OP_SUB:  return sx - sy;
            OP_MUL:  return sx * sy;
            default: return (y == 4'd0) ? 8'sd0 : sx / sy;
        endcase
    endfunction

    // Mode flip is seen against the previous cycle's mode; reset loads the
    // live mode so leaving reset never looks like a mode change.
    assign mode_chg = mode ^ mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTER_A;
            offset     <= '0;
            a          <= '0;
            op         <= OP_ADD;
            b          <= '0;
            mode_q     <= mode;
            digit_code <= {N_DIGITS{CH_BLANK}};
`ifdef MARQUEE_PAUSE_EN
            pause      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            offset     <= offset_n;
            a          <= a_n;
            op         <= op_n;
            b          <= b_n;
            mode_q     <= mode;
            digit_code <= disp_n;
`ifdef MARQUEE_PAUSE_EN
            pause      <= pause_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        offset_n = offset;
        a_n      = a;
        op_n     = op;
        b_n      = b;
`ifdef MARQUEE_PAUSE_EN
        pause_n  = pause;
`endif
        if (mode_chg) begin
            state_n  = ENTER_A;
            offset_n = '0;
        end else if (mode) begin
`ifdef MARQUEE_PAUSE_EN
            if (step)
                pause_n = ~pause;
            if (tick && !pause) begin
`else
            if (tick) begin
`endif
                if (direction)
                    offset_n = (offset == OFF_MAX) ? '0 : offset + 1'b1;
                else
                    offset_n = (offset == '0) ? OFF_MAX : offset - 1'b1;
            end
        end else begin
            // step has priority over tick in the same cycle
            if (step) begin
                case (state)
                    ENTER_A:  state_n = ENTER_OP;
                    ENTER_OP: state_n = ENTER_B;
                    ENTER_B:  state_n = SHOW;
                    SHOW:     state_n = ENTER_A;
                endcase
            end else if (tick) begin
                case (state)
                    ENTER_A:  a_n  = inc_digit(a);
                    ENTER_OP: op_n = op + 2'd1;
                    ENTER_B:  b_n  = inc_digit(b);
                    SHOW:     ;
                endcase
            end
        end
    end

    // Display is built from next-state values so it lands one cycle after
    // the causing event.
    always_comb begin
        disp_n = {N_DIGITS{CH_BLANK}};
        res    = calc_result(a_n, op_n, b_n);
        mag    = res[7] ? 8'(-res) : 8'(res);
        if (mode) begin
            for (int i = 0; i < N_DIGITS; i++)
                disp_n[5*i +: 5] = msg[5*char_idx(offset_n, i) +: 5];
        end else if (state_n == SHOW) begin
            if (op_n == OP_DIV && b_n == 4'd0) begin
                disp_n[4:0] = CH_ERR;
            end else begin
                disp_n[4:0] = 5'(mag % 8'd10);
                if (mag >= 8'd10) begin
                    disp_n[9:5] = 5'(mag / 8'd10);
                    if (res[7])
                        disp_n[14:10] = CH_MINUS;
                end else if (res[7]) begin
                    disp_n[9:5] = CH_MINUS;
                end
            end
        end else begin
            disp_n[5*(N_DIGITS-1) +: 5] = {1'b0, a_n};
            disp_n[5*(N_DIGITS-2) +: 5] = CH_PLUS + {3'b000, op_n};
            disp_n[5*(N_DIGITS-3) +: 5] = {1'b0, b_n};
        end
    end

endmodule
